// File: rtl/cic_decimator.sv
// CIC decimation filter for a 1-bit sigma-delta bitstream: ORDER integrators,
// ORDER combs at the decimated rate, valid/ready output with sticky overrun.
module cic_decimator #(
    parameter int unsigned ORDER = 2,
    parameter int unsigned R_MAX = 64,
    parameter int unsigned RW    = $clog2(R_MAX) + 1,
    parameter int unsigned OUT_W = ORDER * $clog2(R_MAX) + 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             adc_bit,
    input  logic [RW-1:0]    dec_ratio,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic [CNT_W-1:0] sample_count
);

    logic [RW-1:0] ratio_c;
    logic [RW-1:0] r_active;
    logic [RW-1:0] phase;
    logic          frame_end_c;

    // Requested ratio limited to 2..R_MAX
    always_comb begin
        ratio_c = dec_ratio;
        if (dec_ratio < RW'(2)) begin
            ratio_c = RW'(2);
        end else if (dec_ratio > RW'(R_MAX)) begin
            ratio_c = RW'(R_MAX);
        end
    end

    assign frame_end_c = enable && !clear && (phase == r_active - RW'(1));

    // Integrator chain; modular wrap is exact once the combs difference it out
    for (genvar k = 0; k < ORDER; k++) begin : g_int
        logic [OUT_W-1:0] acc;
        logic [OUT_W-1:0] nxt;

        if (k == 0) begin : g_first
            assign nxt = acc + OUT_W'(adc_bit);
        end else begin : g_rest
            assign nxt = acc + g_int[k-1].nxt;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                acc <= '0;
            end else if (clear) begin
                acc <= '0;
            end else if (enable) begin
                acc <= nxt;
            end
        end
    end

    // Comb chain fed by the post-update last integrator, so no extra latency
    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        logic [OUT_W-1:0] din;
        logic [OUT_W-1:0] dly;
        logic [OUT_W-1:0] dout;

        if (k == 0) begin : g_first
            assign din = g_int[ORDER-1].nxt;
        end else begin : g_rest
            assign din = g_comb[k-1].dout;
        end

        assign dout = din - dly;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dly <= '0;
            end else if (clear) begin
                dly <= '0;
            end else if (frame_end_c) begin
                dly <= din;
            end
        end
    end

    // Frame sequencing and output handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase        <= '0;
            r_active     <= ratio_c;
            out_data     <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
            sample_count <= '0;
        end else if (clear) begin
            phase        <= '0;
            r_active     <= ratio_c;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
            sample_count <= '0;
        end else if (frame_end_c) begin
            phase        <= '0;
            r_active     <= ratio_c;
            out_data     <= g_comb[ORDER-1].dout;
            out_valid    <= 1'b1;
            sample_count <= sample_count + CNT_W'(1);
            if (out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end else begin
            if (enable) begin
                phase <= phase + RW'(1);
            end
            if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: ORDER=1 and ORDER=2 instances on shared stimulus,
// checked each cycle against a cumulative-sum / binomial-difference model.
module tb_cic_decimator;

    localparam int unsigned RW = 7;
    localparam int unsigned W1 = 7;
    localparam int unsigned W2 = 13;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          enable;
    logic          adc_bit;
    logic [RW-1:0] dec_ratio;
    logic          out_ready;

    logic [W1-1:0] data1;
    logic          valid1;
    logic          ovr1;
    logic [15:0]   cnt1;
    logic [W2-1:0] data2;
    logic          valid2;
    logic          ovr2;
    logic [15:0]   cnt2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cic_decimator #(.ORDER(1), .R_MAX(64)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable),
        .adc_bit(adc_bit), .dec_ratio(dec_ratio), .out_data(data1),
        .out_valid(valid1), .out_ready(out_ready), .overrun(ovr1),
        .sample_count(cnt1)
    );

    cic_decimator #(.ORDER(2), .R_MAX(64)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable),
        .adc_bit(adc_bit), .dec_ratio(dec_ratio), .out_data(data2),
        .out_valid(valid2), .out_ready(out_ready), .overrun(ovr2),
        .sample_count(cnt2)
    );

    // Reference state per instance (index 0: ORDER=1, index 1: ORDER=2)
    longint      ms   [2][4];
    longint      mh   [2][5];
    int          mph  [2];
    int          mra  [2];
    logic [31:0] mdata[2];
    logic [31:0] mcnt [2];
    bit          mval [2];
    bit          movr [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int clamp(input logic [RW-1:0] r);
        if (r < 2) return 2;
        if (r > 64) return 64;
        return int'(r);
    endfunction

    function automatic longint binom(input int n, input int k);
        longint b = 1;
        for (int i = 0; i < k; i++) b = b * (n - i) / (i + 1);
        return b;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 4; k++) ms[c][k] = 0;
            for (int k = 0; k < 5; k++) mh[c][k] = 0;
            mph[c] = 0; mra[c] = clamp(dec_ratio);
            mdata[c] = 0; mcnt[c] = 0; mval[c] = 0; movr[c] = 0;
        end
    endtask

    // One clock edge of the reference, from current inputs and pre-edge state
    task automatic model_step();
        for (int c = 0; c < 2; c++) begin
            int     n = c + 1;
            longint mask = (longint'(1) << (c == 0 ? W1 : W2)) - 1;
            bit     fe = 0;
            if (clear) begin
                for (int k = 0; k < 4; k++) ms[c][k] = 0;
                for (int k = 0; k < 5; k++) mh[c][k] = 0;
                mph[c] = 0; mra[c] = clamp(dec_ratio);
                mcnt[c] = 0; mval[c] = 0; movr[c] = 0;
            end else begin
                if (enable) begin
                    ms[c][0] += longint'(adc_bit);
                    for (int k = 1; k < n; k++) ms[c][k] += ms[c][k-1];
                    mph[c]++;
                    fe = (mph[c] == mra[c]);
                end
                if (fe) begin
                    longint y = 0;
                    for (int j = n; j > 0; j--) mh[c][j] = mh[c][j-1];
                    mh[c][0] = ms[c][n-1];
                    for (int j = 0; j <= n; j++)
                        y += ((j % 2) ? -1 : 1) * binom(n, j) * mh[c][j];
                    mdata[c] = 32'(y & mask);
                    if (mval[c] && !out_ready) movr[c] = 1;
                    mval[c] = 1;
                    mcnt[c] = (mcnt[c] + 1) & 32'hFFFF;
                    mph[c] = 0;
                    mra[c] = clamp(dec_ratio);
                end else if (out_ready) begin
                    mval[c] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("o1_data",  32'(data1),  mdata[0]);
        chk("o1_valid", 32'(valid1), 32'(mval[0]));
        chk("o1_ovr",   32'(ovr1),   32'(movr[0]));
        chk("o1_cnt",   32'(cnt1),   mcnt[0]);
        chk("o2_data",  32'(data2),  mdata[1]);
        chk("o2_valid", 32'(valid2), 32'(mval[1]));
        chk("o2_ovr",   32'(ovr2),   32'(movr[1]));
        chk("o2_cnt",   32'(cnt2),   mcnt[1]);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Reset pulsed between edges; outputs must read zero before any edge
    task automatic reset_mid();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #3 reset_n = 1'b1;
        model_reset();
    endtask

    logic [RW-1:0] ratio_tab [10];

    initial begin
        ratio_tab = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd8, 7'd16, 7'd100, 7'd127};
        reset_n = 1'b0; clear = 1'b0; enable = 1'b0; adc_bit = 1'b0;
        dec_ratio = 7'd8; out_ready = 1'b1;
        #3;
        model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // All-ones, ratio 8: 8 per frame for ORDER=1, 36 then 64 for ORDER=2
        enable = 1'b1; adc_bit = 1'b1;
        run(40);
        chk("o2_full_scale", 32'(data2), 32'd64);

        // Alternating bits settle to 32 for ORDER=2
        for (int i = 0; i < 48; i++) begin
            adc_bit = i[0];
            cycle();
        end
        chk("o2_half_scale", 32'(data2), 32'd32);

        // Sink stalled for two frames, then released; overrun sticks until clear
        adc_bit = 1'b1; out_ready = 1'b0;
        run(20);
        out_ready = 1'b1;
        run(6);
        clear = 1'b1; cycle(); clear = 1'b0;

        // Mid-frame ratio change 8 -> 16, then ratio 0 behaves as 2
        run(3);
        dec_ratio = 7'd16;
        run(40);
        dec_ratio = 7'd0;
        run(12);
        dec_ratio = 7'd100;
        run(70);

        // Enable toggling at ratio 4, with a clear mid-frame
        dec_ratio = 7'd4;
        clear = 1'b1; cycle(); clear = 1'b0;
        for (int i = 0; i < 40; i++) begin
            enable = ~i[0];
            if (i == 21) clear = 1'b1;
            cycle();
            clear = 1'b0;
        end
        enable = 1'b1;

        // Asynchronous reset mid-frame
        dec_ratio = 7'd8;
        run(5);
        reset_mid();
        run(20);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) dec_ratio = ratio_tab[$urandom_range(0, 9)];
            enable    = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            adc_bit   = 1'($urandom);
            clear     = ($urandom_range(0, 199) == 0);
            cycle();
            clear = 1'b0;
            if ($urandom_range(0, 999) == 0) reset_mid();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
Parametrised CIC (cascaded integrator-comb) decimation filter for a 1-bit sigma-delta ADC bitstream. It is the next generation of the single-accumulator bitstream counter, with three additions: configurable filter order, a runtime-selectable decimation ratio, and a valid/ready output handshake with overrun detection. It sits between the modulator bit output and the downstream sample sink or readout register.

Parameters:
ORDER, 2, number of integrator and comb stages; legal range 1..4; ORDER=1 is a plain windowed bit counter.
R_MAX, 64, maximum decimation ratio; must be a power of two, at least 4.
RW, $clog2(R_MAX)+1, width of the dec_ratio port.
OUT_W, ORDER*$clog2(R_MAX)+1, output width; holds R_MAX^ORDER exactly.
CNT_W, 16, width of the output sample counter.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous clear of filter state; takes priority over enable.
enable  input  1  qualifies adc_bit; when low, integrator, comb and phase state hold.
adc_bit  input  1  modulator bitstream; treated as unsigned 0/1.
dec_ratio  input  RW  requested decimation ratio R.
out_data  output  OUT_W  decimated sample, unsigned.
out_valid  output  1  out_data holds an unconsumed sample.
out_ready  input  1  sink accepts a sample when out_valid and out_ready are both high at a clock edge.
overrun  output  1  sticky flag: an unconsumed sample was overwritten.
sample_count  output  CNT_W  number of samples produced since reset or clear; wraps.

Behaviour:
- Reset (reset_n low, asynchronous): integrators, comb delay registers, phase, out_data, out_valid, overrun and sample_count go to 0. r_active loads the clamped dec_ratio.
- Clamping: a dec_ratio below 2 is treated as 2; a dec_ratio above R_MAX is treated as R_MAX.
- Integrators: on each edge where enable=1, I1 += adc_bit and Ik += I(k-1)_next for k=2..ORDER, all in the same cycle.
  - Each integrator is OUT_W bits wide and wraps modulo 2^OUT_W. The wrap is intentional and the result is exact.
- Phase counter: counts enabled cycles 0..r_active-1.
- Decimation edge: an enabled edge where phase == r_active-1. At this edge:
  - The comb chain is evaluated combinationally on the post-update I_ORDER value. Each comb stage is Ck = in - Dk mod 2^OUT_W, then Dk <= in.
  - out_data <= C_ORDER and sample_count increments, at the same edge. Latency is 0 cycles after the R-th bit.
  - phase returns to 0.
  - r_active reloads from the clamped dec_ratio. A ratio change therefore takes effect only at a frame boundary; a mid-frame change never shortens or lengthens the current frame.
- Steady-state settling: the first ORDER-1 outputs after reset or clear are transient; output ORDER onward is exact. With all-ones input the exact value is R^ORDER (full scale).
- Handshake:
  - A new sample sets out_valid=1.
  - out_valid clears at an edge with out_ready=1, unless a new sample lands at the same edge; then the old sample transfers and the new one loads, out_valid stays 1, and overrun is not set.
  - A new sample while out_valid=1 and out_ready=0 overwrites out_data, keeps out_valid=1 and sets overrun.
  - overrun clears only on reset or clear.
  - out_ready is honoured even when enable=0.
- clear=1 at an edge:
  - Zeros integrators, comb delays, phase, out_valid, overrun and sample_count.
  - Reloads r_active.
  - out_data holds its previous value.
  - The adc_bit sampled at that edge is discarded.
- enable=0: no integration, no phase advance, no output production.
- Reset asserted mid-frame: immediate return to reset values; no partial sample is emitted.

Test Plan:
- ORDER=1, R_MAX=64, dec_ratio=8, enable=1, adc_bit held at 1, out_ready=1 -> out_valid pulses for 1 cycle every 8 cycles; out_data=8 each frame; sample_count increments by 1 per pulse.
- ORDER=2, dec_ratio=8, all-ones input, out_ready=1 -> outputs 36, then 64, 64, ...; with alternating 1/0 input -> steady state 32.
- ORDER=2, dec_ratio=8, out_ready=0 for 2 frames -> out_valid stays 1, overrun=1 after the 2nd sample, out_data=64 (last sample); raising out_ready clears out_valid, overrun stays 1 until clear.
- dec_ratio changed 8->16 at phase 3, all-ones input, ORDER=1 -> current frame still outputs 8; next frame is 16 cycles long and outputs 16; dec_ratio=0 behaves as 2.
- enable toggled 1/0 every cycle, ORDER=1, dec_ratio=4, adc_bit=1 -> one output of 4 every 8 clocks; clear pulse mid-frame -> phase restarts, out_valid=0, sample_count=0, next output is a full 4-bit frame.
- reset_n pulsed low asynchronously mid-frame (between clock edges) -> all outputs read 0 immediately; after release the first output arrives exactly dec_ratio enabled cycles later.
